// File: rtl/board_pkg.sv
// Shared constants and types for the board RAM, VGA geometry and arbiter.
package board_pkg;

  // Board geometry in cells; cells are (1 << CELL_SHIFT) pixels square.
  localparam int unsigned CELL_SHIFT = 4;
  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;

  // 640x480 VGA timing, counted in pixel clocks and lines.
  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned V_VISIBLE  = 480;
  localparam int unsigned H_TOTAL    = 800;
  localparam int unsigned V_TOTAL    = 525;

  // Width of the beam position inputs.
  localparam int unsigned POS_W      = 10;

  // Cell contents as stored in the board RAM.
  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SNAKE = 2'd1,
    CELL_FOOD  = 2'd2,
    CELL_WALL  = 2'd3
  } cell_e;

  // Game-port arbiter states.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StAck  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/board_fetch_sched.sv
// Decides, from the beam position alone, whether this cycle is a video fetch
// slot and which board cell that fetch reads.
module board_fetch_sched #(
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned ROW_W      = 5,
  parameter int unsigned COL_W      = 6
) (
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  output logic             fetch_slot,
  output logic [ROW_W-1:0] fetch_row,
  output logic [COL_W-1:0] fetch_col
);
  import board_pkg::*;

  localparam logic [9:0]  VVisible  = 10'(V_VISIBLE);
  localparam logic [9:0]  VLastVis  = 10'(V_VISIBLE - 1);
  localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HWrapSlot = 10'(H_TOTAL - 2);
  localparam logic [10:0] ColLimit  = 11'(GRID_W);

  logic [10:0] next_col;
  logic [10:0] next_y;
  logic        slot_a;
  logic        slot_b;

  // Slot a: two pixels before a cell boundary inside a visible line fetch the
  // next cell. Slot b: near the end of a line fetch column 0 of the next line.
  always_comb begin
    next_col = {1'b0, pos_x >> CELL_SHIFT} + 11'd1;
    next_y   = {1'b0, pos_y} + 11'd1;

    slot_a = (pos_y < VVisible) &&
             (pos_x[CELL_SHIFT-1:0] == {{(CELL_SHIFT-1){1'b1}}, 1'b0}) &&
             (next_col < ColLimit);
    slot_b = (pos_x == HWrapSlot) && ((pos_y < VLastVis) || (pos_y == VLast));

    fetch_slot = slot_a | slot_b;
    fetch_col  = slot_a ? COL_W'(next_col) : '0;

    if (slot_a) begin
      fetch_row = ROW_W'(pos_y >> CELL_SHIFT);
    end else if (pos_y == VLast) begin
      fetch_row = '0;
    end else begin
      fetch_row = ROW_W'(next_y >> CELL_SHIFT);
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the single-port board RAM between video scan-out (which always wins)
// and the game engine's req/ack port; also produces the per-frame tick.
module board_mem_arbiter #(
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic [DATA_W-1:0] vid_cell,
  output logic              frame_tick,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import board_pkg::*;

  localparam int unsigned      ROW_W     = $clog2(GRID_H);
  localparam int unsigned      COL_W     = $clog2(GRID_W);
  localparam logic [ADDR_W-1:0] NumCells  = ADDR_W'(GRID_W * GRID_H);
  localparam logic [ADDR_W-1:0] RowStride = ADDR_W'(GRID_W);
  localparam logic [9:0]        VVisible  = 10'(V_VISIBLE);

  logic             fetch_slot;
  logic [ROW_W-1:0] fetch_row;
  logic [COL_W-1:0] fetch_col;
  logic [ADDR_W-1:0] video_addr;

  arb_state_e        state_q, state_d;
  logic              oor_q, oor_d;
  logic              fetch_q, fetch_d;
  logic [DATA_W-1:0] vid_cell_q, vid_cell_d;
  logic              grant;
  logic              game_oor;

  board_fetch_sched #(
    .CELL_SHIFT (CELL_SHIFT),
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_fetch_sched (
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .fetch_slot (fetch_slot),
    .fetch_row  (fetch_row),
    .fetch_col  (fetch_col)
  );

  // Grant decision and next-state: the game port only gets the RAM on an idle,
  // non-fetch cycle; the cycle after any fetch slot latches the video data.
  always_comb begin
    // Constant multiply; for the 40-wide board this is row*32 + row*8.
    video_addr = ADDR_W'(fetch_row) * RowStride + ADDR_W'(fetch_col);
    game_oor   = (game_addr >= NumCells);
    grant      = !reset && (state_q == StIdle) && game_req && !fetch_slot;

    state_d    = state_q;
    oor_d      = oor_q;
    fetch_d    = fetch_slot;
    vid_cell_d = vid_cell_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StAck;
          oor_d   = game_oor;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fetch_q) begin
      vid_cell_d = mem_rdata;
    end
  end

  // Arbiter state, out-of-range flag, fetch pipeline and video cell register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      oor_q      <= 1'b0;
      fetch_q    <= 1'b0;
      vid_cell_q <= '0;
    end else begin
      state_q    <= state_d;
      oor_q      <= oor_d;
      fetch_q    <= fetch_d;
      vid_cell_q <= vid_cell_d;
    end
  end

  // RAM port drive, game handshake and frame tick. Reset masks every output
  // in the same cycle so a pending ack is dropped rather than delivered late.
  always_comb begin
    mem_addr   = grant ? game_addr : video_addr;
    mem_we     = grant && game_we && !game_oor;
    mem_wdata  = game_wdata;
    game_ack   = !reset && (state_q == StAck);
    game_rdata = (game_ack && !oor_q) ? mem_rdata : '0;
    vid_cell   = reset ? '0 : vid_cell_q;
    frame_tick = !reset && (pos_x == '0) && (pos_y == VVisible);
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: a behavioural RAM sits on the memory
// port, game transactions go through a scoreboard, and the beam position is
// driven directly so regions of a frame can be visited without full frames.
module tb_board_mem_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 2;
  localparam int NCELL = 1200;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    pos_x, pos_y;
  logic [DW-1:0] vid_cell;
  logic          frame_tick;
  logic          game_req, game_we;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          game_ack;
  logic [DW-1:0] game_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] shadow [NCELL];
  bit            loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_x, cur_y, cyc;
  int vid_exp = -1;
  bit ack_seen;
  int ack_x, ack_y, ack_cyc;
  int we_cnt, tick_cnt;
  int lat, c1, c2, c3, c4;

  logic [DW-1:0] sb_exp [$];
  bit            sb_chk [$];
  string         sb_tag [$];

  board_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .vid_cell   (vid_cell),
    .frame_tick (frame_tick),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_ack   (game_ack),
    .game_rdata (game_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_cell(int i);
    if (i < NCELL) return 2'((i / 40 + i % 40) % 4);
    return 2'd3;
  endfunction

  // Synchronous-read board RAM, preloaded on the first edge.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2**AW; i++) ram[i] <= init_cell(i);
      loaded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference fetch schedule written from the slot rules.
  function automatic bit exp_slot(input int x, input int y, output int addr);
    int row;
    addr = 0;
    if (y < 480 && x % 16 == 14 && x / 16 + 1 < 40) begin
      addr = (y / 16) * 40 + x / 16 + 1;
      return 1'b1;
    end
    if (x == 798 && (y < 479 || y == 524)) begin
      row  = (y == 524) ? 0 : (y + 1) / 16;
      addr = row * 40;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock at beam position (cur_x, cur_y); checks sampled at the negedge.
  task automatic step();
    int ea;
    bit es;
    logic [DW-1:0] e;
    bit ck;
    string t;
    pos_x = 10'(cur_x);
    pos_y = 10'(cur_y);
    @(negedge clk);
    es = exp_slot(cur_x, cur_y, ea);
    if (es) begin
      check($sformatf("fetch_addr@%0d,%0d", cur_x, cur_y), 32'(mem_addr), ea);
      check($sformatf("fetch_we@%0d,%0d", cur_x, cur_y), 32'(mem_we), 0);
    end
    if (mem_we === 1'b1) begin
      we_cnt++;
      check("we_in_range", 32'(mem_addr < 11'(NCELL)), 1);
    end
    if (reset === 1'b1) begin
      check("rst_ack", 32'(game_ack), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_vid", 32'(vid_cell), 0);
      check("rst_tick", 32'(frame_tick), 0);
    end
    if (vid_exp >= 0) check($sformatf("vid_cell@%0d,%0d", cur_x, cur_y), 32'(vid_cell), vid_exp);
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      check("tick_pos", 32'(cur_y * 1024 + cur_x), 480 * 1024);
    end
    if (game_ack === 1'b1) begin
      ack_seen = 1'b1;
      ack_x    = cur_x;
      ack_y    = cur_y;
      ack_cyc  = cyc;
      if (sb_exp.size() == 0) begin
        check("unexpected_ack", 32'(game_ack), 0);
      end else begin
        e  = sb_exp.pop_front();
        ck = sb_chk.pop_front();
        t  = sb_tag.pop_front();
        if (ck) check(t, 32'(game_rdata), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    cur_x++;
    if (cur_x == 800) begin
      cur_x = 0;
      cur_y = (cur_y + 1) % 525;
    end
  endtask

  // Issue one game access and step until its ack (bounded).
  task automatic game_access(input bit we, input int addr, input logic [DW-1:0] wd,
                             input logic [DW-1:0] exp_rd, input string tag, input bit keep,
                             output int lat_o);
    game_req   = 1'b1;
    game_we    = we;
    game_addr  = 11'(addr);
    game_wdata = wd;
    sb_exp.push_back(exp_rd);
    sb_chk.push_back(!we);
    sb_tag.push_back(tag);
    ack_seen = 1'b0;
    lat_o    = 0;
    while (!ack_seen && lat_o < 8) begin
      step();
      lat_o++;
    end
    if (!keep) game_req = 1'b0;
    if (!ack_seen) begin
      check({tag, "_timeout"}, 32'(ack_seen), 1);
      void'(sb_exp.pop_front());
      void'(sb_chk.pop_front());
      void'(sb_tag.pop_front());
    end
  endtask

  // Cross from the end of line 16 into line 17 and check every pixel of 17.
  task automatic sweep_row17();
    cur_x = 790;
    cur_y = 16;
    repeat (10) step();
    for (int x = 0; x < 800; x++) begin
      vid_exp = int'(shadow[40 + ((x < 640) ? x / 16 : 39)]);
      step();
    end
    vid_exp = -1;
  endtask

  initial begin
    for (int i = 0; i < NCELL; i++) shadow[i] = init_cell(i);
    reset      = 1'b1;
    game_req   = 1'b1;
    game_we    = 1'b0;
    game_addr  = 11'd45;
    game_wdata = '0;

    // Reset with a request held; release so that (0,0) is the last reset cycle.
    cur_x = 790;
    cur_y = 524;
    repeat (11) step();
    reset = 1'b0;
    game_access(1'b0, 45, 2'd0, shadow[45], "rst_read", 1'b0, lat);
    check("rst_ack_x", 32'(ack_x), 2);
    check("rst_ack_y", 32'(ack_y), 0);
    check("rst_lat", 32'(lat), 2);

    // Row 1 scan-out against the preloaded pattern, including blanking hold.
    sweep_row17();

    // Write colliding with a fetch slot is deferred one cycle.
    cur_x = 14;
    cur_y = 0;
    we_cnt = 0;
    game_access(1'b1, 45, 2'd3, 2'd0, "wr45", 1'b0, lat);
    check("wr45_ack_x", 32'(ack_x), 16);
    check("wr45_lat", 32'(lat), 3);
    check("wr45_we_cnt", 32'(we_cnt), 1);
    shadow[45] = 2'd3;
    sweep_row17();

    // Back-to-back reads with req held: acks exactly two cycles apart.
    cur_x = 100;
    cur_y = 500;
    we_cnt = 0;
    game_access(1'b0, 0, 2'd0, shadow[0], "rd0", 1'b1, lat);
    c1 = ack_cyc;
    check("rd0_lat", 32'(lat), 2);
    game_access(1'b0, 1199, 2'd0, shadow[1199], "rd1199", 1'b1, lat);
    c2 = ack_cyc;
    game_access(1'b0, 45, 2'd0, shadow[45], "rd45", 1'b1, lat);
    c3 = ack_cyc;
    game_access(1'b0, 41, 2'd0, shadow[41], "rd41", 1'b0, lat);
    c4 = ack_cyc;
    check("b2b_gap1", 32'(c2 - c1), 2);
    check("b2b_gap2", 32'(c3 - c2), 2);
    check("b2b_gap3", 32'(c4 - c3), 2);
    check("b2b_no_we", 32'(we_cnt), 0);

    // Out-of-range write is acked but never reaches the RAM; read returns 0.
    cur_x = 200;
    cur_y = 500;
    we_cnt = 0;
    game_access(1'b1, 1200, 2'd1, 2'd0, "wr_oor", 1'b0, lat);
    check("oor_lat", 32'(lat), 2);
    check("oor_no_we", 32'(we_cnt), 0);
    game_access(1'b0, 1200, 2'd0, 2'd0, "rd_oor", 1'b0, lat);

    // Reset during the ack cycle drops the ack.
    cur_x = 300;
    cur_y = 500;
    game_req  = 1'b1;
    game_we   = 1'b0;
    game_addr = 11'd1;
    step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    game_req = 1'b0;
    repeat (3) step();

    // Line wrap into the new frame, then the vblank tick around line 480.
    cur_x = 790;
    cur_y = 524;
    repeat (20) step();
    tick_cnt = 0;
    cur_x = 0;
    cur_y = 478;
    repeat (800 * 4) step();
    check("tick_count", 32'(tick_cnt), 1);
    check("sb_empty", 32'(sb_exp.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
